pipe_stage_ctrl: RTL and testbench
==================================

# pipe_stage_ctrl

Sequencing controller for a linear pipeline built from clearable/enabled flop stages. It turns per-stage stall and flush requests into per-stage enable and clear strobes and tracks a valid bit per stage. It also runs a drain sequence that stops intake and waits for the pipeline to empty. It sits beside the datapath and drives the `en`/`clear` pins of each stage register; it holds no payload data itself.

## Interface
- `STAGES`, default 5: number of pipeline register stages, ≥2. Stage 0 is the input and stage `STAGES-1` is the output.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: upstream presents a new item.
- `in_ready` output, 1 bit: stage 0 will capture the item this cycle.
- `stall_req` input, `STAGES` bits: bit i means stage i cannot advance.
- `flush_req` input, `STAGES` bits: bit i kills stages 0..i.
- `drain` input, 1 bit: request to stop intake and empty the pipe.
- `en` output, `STAGES` bits: load enable for each stage register.
- `clr` output, `STAGES` bits: synchronous clear for each stage register.
- `valid` output, `STAGES` bits: registered occupancy per stage.
- `out_fire` output, 1 bit: the item in the last stage retires this cycle.
- `drained` output, 1 bit: registered; high in state DONE.

## Operation
- Stall propagation:
  - Let k be the highest index with `stall_req[k]`=1.
  - `en[j]`=0 for all j≤k. All other stages have `en`=1.
  - With no stall, all `en`=1.
- Bubble insertion: if k<`STAGES-1`, then `clr[k+1]`=1, so the stage after a stall loads a bubble.
- Flush:
  - Let f be the highest index with `flush_req[f]`=1.
  - `clr[j]`=1 for all j≤f.
  - A stage with both `clr` and `en` clears. Clear dominates stall.
- Valid tracking, evaluated per stage each cycle in this priority order:
  1. If `clr[i]`: `valid[i]` ← 0.
  2. Else if `en[i]`: `valid[i]` ← `valid[i-1]`, with stage 0 taking `in_valid & in_ready`.
  3. Else `valid[i]` holds.
- `in_ready` = `en[0]` & ~`clr[0]` & (state==RUN) & ~`reset`.
- `out_fire` = `valid[STAGES-1]` & ~`stall_req[STAGES-1]` & ~`clr[STAGES-1]`.
- FSM states are RUN, DRAIN and DONE.
  - RUN: intake is enabled. On `drain`=1, go to DRAIN.
  - DRAIN:
    - `in_ready`=0, so bubbles enter stage 0.
    - Go to DONE when the next-state valid vector is all zero.
    - If `drain` drops before the pipe is empty, return to RUN and resume intake the next cycle.
  - DONE: `drained`=1 and intake stays blocked. When `drain`=0, go to RUN.
- Flushes and stalls stay active in every state. A flush during DRAIN can finish the drain early.
- If `drain`=1 in RUN and the pipe is already empty, go DRAIN → DONE on consecutive cycles. DONE is not skipped.

## Timing
- While `reset`=1:
  - Outputs: `clr`=all ones, `en`=all zeros, `in_ready`=0, `out_fire`=0.
  - Registers: `valid`=0, state=RUN, `drained`=0.
- First cycle after reset: `in_ready`=1 if no stall or flush is requested.
- `en`, `clr`, `in_ready` and `out_fire` are combinational from the current inputs and registered state, with no added latency.
- An item accepted at cycle t, with no stalls, has `valid[i]`=1 at cycle t+1+i. `out_fire` occurs at cycle t+`STAGES`.
- A stall held for n cycles delays every upstream item by exactly n cycles. Downstream items keep moving.
- `drained` rises on the cycle after the last valid bit clears.
- When `drain` falls in DONE, `drained` goes low and intake becomes possible on the next cycle.
- Reset asserted mid-operation takes precedence over everything. All valids clear and the FSM returns to RUN.

## Test plan
- **Streaming:** `STAGES`=5, `in_valid`=1 for 10 cycles, no stalls → `valid` fills 00001→11111 over 5 cycles, then `out_fire`=1 for 10 consecutive cycles starting 5 cycles after the first accept.
- **Mid-pipe stall:** full pipe, `stall_req[2]`=1 for 3 cycles → `en`=11000, `clr[3]`=1. A 3-cycle bubble appears in `valid[3]`. `in_ready`=0 throughout the stall.
- **Flush dominates stall:** full pipe, `flush_req[3]`=1 and `stall_req[1]`=1 in the same cycle → `clr`=01111. Next cycle `valid`=10000, with stage 4 retained and only the stage-4 item live.
- **Drain:** `drain`=1 with 3 items in flight → `in_ready`=0 immediately. `drained`=1 exactly one cycle after the last `out_fire`. Dropping `drain` → `in_ready`=1 on the next cycle.
- **Drain abort:** `drain` pulsed for 1 cycle with a full pipe → FSM goes RUN→DRAIN→RUN, exactly one cycle of intake is lost, and no item is lost.
- **Reset mid-stream:** full pipe, `reset` for 1 cycle → `valid`=0, `clr`=11111 during reset, no `out_fire` for 5 cycles afterwards, and `drained`=0.

Source files
------------

// File: rtl/pipe_stage_ctrl_if.sv
// Handshake and per-stage control bundle between a pipeline sequencer and its environment.
// The master drives requests; the slave (the controller) drives strobes and status.
interface pipe_stage_ctrl_if #(
  parameter int STAGES = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [STAGES-1:0] stall_req;
  logic [STAGES-1:0] flush_req;
  logic              drain;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] clr;
  logic [STAGES-1:0] valid;
  logic              out_fire;
  logic              drained;

  modport master (
    output in_valid, stall_req, flush_req, drain,
    input  in_ready, en, clr, valid, out_fire, drained
  );

  modport slave (
    input  in_valid, stall_req, flush_req, drain,
    output in_ready, en, clr, valid, out_fire, drained
  );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Turns per-stage stall/flush requests into enable/clear strobes for a linear pipeline,
// tracks per-stage occupancy and sequences a drain (RUN -> DRAIN -> DONE).
module pipe_stage_ctrl #(
  parameter int STAGES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_stage_ctrl_if.slave      bus
);

  localparam int LAST = STAGES - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic              drained_q, drained_d;
  logic [STAGES-1:0] en_s, clr_s;
  logic              stall_acc_s, flush_acc_s;
  logic              in_ready_s, out_fire_s;

  // Stage strobes: a stall freezes itself and everything upstream; a flush clears itself and upstream.
  always_comb begin
    en_s        = '0;
    clr_s       = '1;
    stall_acc_s = 1'b0;
    flush_acc_s = 1'b0;
    if (reset) begin
      en_s  = '0;
      clr_s = '1;
    end else begin
      for (int i = LAST; i >= 0; i--) begin
        stall_acc_s = stall_acc_s | bus.stall_req[i];
        flush_acc_s = flush_acc_s | bus.flush_req[i];
        en_s[i]     = ~stall_acc_s;
        clr_s[i]    = flush_acc_s;
      end
      // The first enabled stage below a frozen one must load a bubble, not a duplicate.
      for (int i = 1; i < STAGES; i++) begin
        clr_s[i] = clr_s[i] | (en_s[i] & ~en_s[i-1]);
      end
    end
  end

  // Handshake outputs derived from strobes and FSM state.
  always_comb begin
    in_ready_s = en_s[0] & ~clr_s[0] & (state_q == ST_RUN) & ~reset;
    out_fire_s = valid_q[LAST] & ~bus.stall_req[LAST] & ~clr_s[LAST];
  end

  // Occupancy next-state: clear beats load, load beats hold.
  always_comb begin
    valid_d = valid_q;
    if (clr_s[0]) begin
      valid_d[0] = 1'b0;
    end else if (en_s[0]) begin
      valid_d[0] = bus.in_valid & in_ready_s;
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int i = 1; i < STAGES; i++) begin
      if (clr_s[i]) begin
        valid_d[i] = 1'b0;
      end else if (en_s[i]) begin
        valid_d[i] = valid_q[i-1];
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  // FSM next state; dropping drain always wins over completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.drain) state_d = ST_DRAIN;
        else           state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (!bus.drain)         state_d = ST_RUN;
        else if (valid_d == '0) state_d = ST_DONE;
        else                    state_d = ST_DRAIN;
      end
      ST_DONE: begin
        if (bus.drain) state_d = ST_DONE;
        else           state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    drained_d = (state_d == ST_DONE);
  end

  // State, occupancy and drained flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      valid_q   <= '0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      drained_q <= drained_d;
    end
  end

  assign bus.en       = en_s;
  assign bus.clr      = clr_s;
  assign bus.in_ready = in_ready_s;
  assign bus.out_fire = out_fire_s;
  assign bus.valid    = valid_q;
  assign bus.drained  = drained_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl with STAGES=5: streaming, stalls, flush, drain,
// drain abort and mid-stream reset, all against hand-computed expectations.
module tb_pipe_stage_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   fire_cnt = 0;
  int   fire_base;
  logic [4:0] exp_v;
  logic [4:0] stall_tbl [3];

  pipe_stage_ctrl_if #(.STAGES(5)) bus ();

  pipe_stage_ctrl #(.STAGES(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.out_fire) fire_cnt <= fire_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    bus.in_valid = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.stall_req = 5'b00000;
    bus.flush_req = 5'b00000;
    bus.drain     = 1'b0;
    stall_tbl[0]  = 5'b10111;
    stall_tbl[1]  = 5'b00111;
    stall_tbl[2]  = 5'b00111;

    // reset state
    #1;
    chk("rst_clr", bus.clr, 5'b11111);
    chk("rst_en", bus.en, 5'b00000);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_fire", bus.out_fire, 1'b0);
    tick();
    chk("rst_valid", bus.valid, 5'b00000);
    chk("rst_drained", bus.drained, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // streaming: 10 items, item t sits in stage i at t+1+i and retires at t+5
    for (int c = 0; c < 16; c++) begin
      bus.in_valid = (c < 10);
      #1;
      chk("stream_fire", bus.out_fire, (c >= 5 && c <= 14));
      chk("stream_ready", bus.in_ready, 1'b1);
      tick();
      exp_v = 5'b00000;
      for (int i = 0; i < 5; i++) begin
        if (c - i >= 0 && c - i <= 9) exp_v[i] = 1'b1;
      end
      chk("stream_valid", bus.valid, exp_v);
    end

    // stall on the last stage: everything frozen, no bubble, no retire
    fill();
    chk("full_valid", bus.valid, 5'b11111);
    bus.stall_req = 5'b10000;
    #1;
    chk("last_stall_en", bus.en, 5'b00000);
    chk("last_stall_clr", bus.clr, 5'b00000);
    chk("last_stall_fire", bus.out_fire, 1'b0);
    chk("last_stall_ready", bus.in_ready, 1'b0);

    // mid-pipe stall on stage 2 for 3 cycles
    bus.stall_req = 5'b00100;
    #1;
    chk("mid_stall_en", bus.en, 5'b11000);
    for (int s = 0; s < 3; s++) begin
      chk("mid_stall_clr", bus.clr, 5'b01000);
      chk("mid_stall_ready", bus.in_ready, 1'b0);
      tick();
      chk("mid_stall_valid", bus.valid, stall_tbl[s]);
    end
    bus.stall_req = 5'b00000;
    tick();
    chk("stall_rel_valid0", bus.valid, 5'b01111);
    tick();
    chk("stall_rel_valid1", bus.valid, 5'b11111);

    // flush of stage 3 together with stall of stage 1
    bus.flush_req = 5'b01000;
    bus.stall_req = 5'b00010;
    #1;
    chk("flush_clr", bus.clr, 5'b01111);
    chk("flush_en", bus.en, 5'b11100);
    chk("flush_ready", bus.in_ready, 1'b0);
    chk("flush_fire", bus.out_fire, 1'b1);
    tick();
    chk("flush_valid", bus.valid, 5'b10000);
    bus.flush_req = 5'b00000;
    bus.stall_req = 5'b00000;
    bus.in_valid  = 1'b0;

    // drain with 3 items in flight
    tick();
    bus.in_valid = 1'b1;
    repeat (3) tick();
    chk("drain_pre_valid", bus.valid, 5'b00111);
    bus.in_valid = 1'b0;
    bus.drain    = 1'b1;
    tick();
    chk("drain_ready", bus.in_ready, 1'b0);
    chk("drain_valid", bus.valid, 5'b01110);
    chk("drain_fire0", bus.out_fire, 1'b0);
    tick();
    chk("drain_fire1", bus.out_fire, 1'b1);
    tick();
    chk("drain_fire2", bus.out_fire, 1'b1);
    tick();
    chk("drain_fire3", bus.out_fire, 1'b1);
    chk("drain_not_yet", bus.drained, 1'b0);
    tick();
    chk("drained_rise", bus.drained, 1'b1);
    chk("drained_valid", bus.valid, 5'b00000);
    tick();
    chk("done_hold", bus.drained, 1'b1);
    chk("done_ready", bus.in_ready, 1'b0);
    bus.drain = 1'b0;
    #1;
    chk("done_exit_ready", bus.in_ready, 1'b0);
    tick();
    chk("done_exit_drained", bus.drained, 1'b0);
    chk("resume_ready", bus.in_ready, 1'b1);

    // drain abort: one-cycle drain pulse on a full pipe loses one intake slot, no items
    fire_base = fire_cnt;
    fill();
    bus.drain = 1'b1;
    #1;
    chk("abort_a0_ready", bus.in_ready, 1'b1);
    tick();
    bus.drain = 1'b0;
    #1;
    chk("abort_a1_ready", bus.in_ready, 1'b0);
    tick();
    chk("abort_a2_ready", bus.in_ready, 1'b1);
    chk("abort_a2_valid", bus.valid, 5'b11110);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    chk("abort_empty", bus.valid, 5'b00000);
    chk("abort_fires", fire_cnt - fire_base, 7);

    // reset mid-stream
    fill();
    reset = 1'b1;
    #1;
    chk("mrst_clr", bus.clr, 5'b11111);
    chk("mrst_en", bus.en, 5'b00000);
    chk("mrst_ready", bus.in_ready, 1'b0);
    chk("mrst_fire", bus.out_fire, 1'b0);
    tick();
    chk("mrst_valid", bus.valid, 5'b00000);
    chk("mrst_drained", bus.drained, 1'b0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("mrst_no_fire", bus.out_fire, 1'b0);
      tick();
    end
    chk("mrst_drained_end", bus.drained, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
